// File: rtl/pc_exception_unit.sv
// Program counter and exception-return state for the multicycle MIPS core.
// Optional fetch-timeout fallback is enabled by defining PC_EXC_TIMEOUT_EN.
module pc_exception_unit #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter logic [31:0] VEC_BASE        = 32'd253,
    parameter logic [31:0] EPC_OFFSET      = 32'd4
`ifdef PC_EXC_TIMEOUT_EN
    ,
    parameter int          TIMEOUT_CYCLES  = 16,
    parameter logic [31:0] DEFAULT_HANDLER = 32'h0000_00FC
`endif
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] next_pc,
    input  logic        pc_write,
    input  logic        pc_write_cond,
    input  logic        branch_taken,
    input  logic        exc_opcode,
    input  logic        exc_overflow,
    input  logic        exc_div_zero,
    input  logic        vec_ready,
    input  logic [7:0]  vec_rdata,
    output logic [31:0] pc_output,
    output logic [31:0] epc_output,
    output logic [31:0] exception_address,
    output logic        vec_rd,
    output logic [31:0] vec_addr,
    output logic        exc_busy,
    output logic        exc_done,
    output logic [1:0]  exc_cause,
    output logic        exc_timeout
);

    typedef enum logic [1:0] {IDLE, SAVE, FETCH, LOAD} state_t;

    state_t      state_q;
    logic [31:0] pc_q, epc_q, exc_addr_q, vec_addr_q;
    logic        vec_rd_q, busy_q, done_q;
    logic [1:0]  cause_q;

    logic        exc_req, pc_we;
    logic [1:0]  cause_d;

`ifdef PC_EXC_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tmo_cnt_q;
    logic          timeout_q;
`endif

    // Fixed priority: opcode > overflow > div_zero; lower simultaneous requests are dropped.
    always_comb begin
        exc_req = exc_opcode | exc_overflow | exc_div_zero;
        pc_we   = pc_write | (pc_write_cond & branch_taken);
        cause_d = 2'd2;
        if (exc_opcode)
            cause_d = 2'd0;
        else if (exc_overflow)
            cause_d = 2'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            epc_q      <= '0;
            exc_addr_q <= '0;
            vec_addr_q <= '0;
            vec_rd_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cause_q    <= 2'd0;
`ifdef PC_EXC_TIMEOUT_EN
            tmo_cnt_q  <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (exc_req) begin
                        cause_q <= cause_d;
                        busy_q  <= 1'b1;
                        state_q <= SAVE;
                    end else if (pc_we) begin
                        pc_q <= next_pc;
                    end
                end
                SAVE: begin
                    epc_q      <= pc_q - EPC_OFFSET;
                    vec_addr_q <= VEC_BASE + {30'd0, cause_q};
                    vec_rd_q   <= 1'b1;
`ifdef PC_EXC_TIMEOUT_EN
                    tmo_cnt_q  <= '0;
`endif
                    state_q    <= FETCH;
                end
                FETCH: begin
                    if (vec_ready) begin
                        exc_addr_q <= {24'd0, vec_rdata};
                        vec_rd_q   <= 1'b0;
                        state_q    <= LOAD;
                    end
`ifdef PC_EXC_TIMEOUT_EN
                    else if (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                        exc_addr_q <= DEFAULT_HANDLER;
                        timeout_q  <= 1'b1;
                        vec_rd_q   <= 1'b0;
                        state_q    <= LOAD;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
`endif
                end
                LOAD: begin
                    pc_q    <= exc_addr_q;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pc_output         = pc_q;
    assign epc_output        = epc_q;
    assign exception_address = exc_addr_q;
    assign vec_rd            = vec_rd_q;
    assign vec_addr          = vec_addr_q;
    assign exc_busy          = busy_q;
    assign exc_done          = done_q;
    assign exc_cause         = cause_q;
`ifdef PC_EXC_TIMEOUT_EN
    assign exc_timeout       = timeout_q;
`else
    assign exc_timeout       = 1'b0;
`endif

endmodule

// File: tb/tb_pc_exception_unit.sv
// Directed bench for pc_exception_unit: PC writes, exception sequencing, priority, EPC wrap, async abort.
module tb_pc_exception_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] next_pc;
  logic        pc_write, pc_write_cond, branch_taken;
  logic        exc_opcode, exc_overflow, exc_div_zero;
  logic        vec_ready;
  logic [7:0]  vec_rdata;
  logic [31:0] pc_output, epc_output, exception_address, vec_addr;
  logic        vec_rd, exc_busy, exc_done, exc_timeout;
  logic [1:0]  exc_cause;

  int n_chk  = 0;
  int n_pass = 0;

  pc_exception_unit dut (
    .clk(clk), .reset_n(reset_n), .next_pc(next_pc),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_taken(branch_taken),
    .exc_opcode(exc_opcode), .exc_overflow(exc_overflow), .exc_div_zero(exc_div_zero),
    .vec_ready(vec_ready), .vec_rdata(vec_rdata),
    .pc_output(pc_output), .epc_output(epc_output), .exception_address(exception_address),
    .vec_rd(vec_rd), .vec_addr(vec_addr), .exc_busy(exc_busy), .exc_done(exc_done),
    .exc_cause(exc_cause), .exc_timeout(exc_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; next_pc = '0; pc_write = 0; pc_write_cond = 0; branch_taken = 0;
    exc_opcode = 0; exc_overflow = 0; exc_div_zero = 0; vec_ready = 0; vec_rdata = '0;
    step(); step();
    chk("rst_pc", pc_output, 32'h0);
    chk("rst_epc", epc_output, 32'h0);
    chk("rst_exa", exception_address, 32'h0);
    chk("rst_vaddr", vec_addr, 32'h0);
    chk("rst_flags", {27'd0, vec_rd, exc_busy, exc_done, exc_cause}, 32'h0);
    chk("rst_tmo", {31'd0, exc_timeout}, 32'h0);
    reset_n = 1'b1;

    // plain and conditional PC writes
    pc_write = 1; next_pc = 32'h40; step(); pc_write = 0;
    chk("pc_write", pc_output, 32'h40);
    pc_write_cond = 1; branch_taken = 0; next_pc = 32'h80; step();
    chk("cond_not_taken", pc_output, 32'h40);
    branch_taken = 1; step(); pc_write_cond = 0; branch_taken = 0;
    chk("cond_taken", pc_output, 32'h80);
    pc_write = 1; next_pc = 32'h104; step(); pc_write = 0;
    chk("pc_104", pc_output, 32'h104);

    // overflow exception with vec_ready held high: done 4 edges after request
    exc_overflow = 1; vec_ready = 1; vec_rdata = 8'h80; step(); exc_overflow = 0;
    chk("ovf_busy", {31'd0, exc_busy}, 32'h1);
    chk("ovf_cause", {30'd0, exc_cause}, 32'h1);
    step();
    chk("ovf_epc", epc_output, 32'h100);
    chk("ovf_vaddr", vec_addr, 32'd254);
    chk("ovf_vrd", {31'd0, vec_rd}, 32'h1);
    step();
    chk("ovf_exa", exception_address, 32'h80);
    chk("ovf_done_early", {30'd0, vec_rd, exc_done}, 32'h0);
    step();
    chk("ovf_pc", pc_output, 32'h80);
    chk("ovf_done", {30'd0, exc_done, exc_busy}, 32'h2);
    step();
    chk("ovf_done_pulse", {31'd0, exc_done}, 32'h0);
    vec_ready = 0;

    // simultaneous requests plus PC write: opcode wins, write discarded
    exc_opcode = 1; exc_div_zero = 1; pc_write = 1; next_pc = 32'h55; step();
    exc_opcode = 0; exc_div_zero = 0; pc_write = 0;
    chk("pri_cause", {30'd0, exc_cause}, 32'h0);
    chk("pri_pc_kept", pc_output, 32'h80);
    step();
    chk("pri_vaddr", vec_addr, 32'd253);
    chk("pri_epc", epc_output, 32'h7C);
    // requests and writes during FETCH are ignored
    exc_overflow = 1; pc_write = 1; next_pc = 32'h999; step(); step();
    exc_overflow = 0; pc_write = 0;
    chk("fetch_hold", {30'd0, vec_rd, exc_busy}, 32'h3);
    chk("fetch_cause", {30'd0, exc_cause}, 32'h0);
    chk("fetch_pc", pc_output, 32'h80);
    vec_rdata = 8'h30; vec_ready = 1; step(); vec_ready = 0;
    chk("pri_exa", exception_address, 32'h30);
    step();
    chk("pri_pc", pc_output, 32'h30);
    chk("pri_done", {31'd0, exc_done}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("single_done", {30'd0, exc_done, exc_busy}, 32'h0);
    end

    // EPC wrap from PC=0
    pc_write = 1; next_pc = 32'h0; step(); pc_write = 0;
    exc_div_zero = 1; vec_ready = 1; vec_rdata = 8'hFF; step(); exc_div_zero = 0;
    chk("dz_cause", {30'd0, exc_cause}, 32'h2);
    step();
    chk("dz_epc_wrap", epc_output, 32'hFFFF_FFFC);
    chk("dz_vaddr", vec_addr, 32'd255);
    step(); step(); vec_ready = 0;
    chk("dz_pc", pc_output, 32'hFF);
    pc_write = 1; next_pc = 32'h200; step(); pc_write = 0;
    chk("epc_hold", epc_output, 32'hFFFF_FFFC);
    chk("exa_hold", exception_address, 32'hFF);
    chk("cause_hold", {30'd0, exc_cause}, 32'h2);

    // asynchronous reset mid-sequence, no clock edge needed
    exc_opcode = 1; step(); exc_opcode = 0; step();
    #2 reset_n = 1'b0;
    #1;
    chk("arst_pc", pc_output, 32'h0);
    chk("arst_flags", {29'd0, exc_busy, vec_rd, exc_done}, 32'h0);
    chk("arst_epc", epc_output, 32'h0);
    reset_n = 1'b1;
    step(); step();
    chk("arst_idle", {30'd0, exc_busy, vec_rd}, 32'h0);

`ifdef PC_EXC_TIMEOUT_EN
    pc_write = 1; next_pc = 32'h10; step(); pc_write = 0;
    exc_overflow = 1; vec_ready = 0; step(); exc_overflow = 0;
    step();
    for (int i = 0; i < 15; i++) step();
    chk("tmo_wait", {30'd0, vec_rd, exc_timeout}, 32'h2);
    step();
    chk("tmo_hit", {30'd0, vec_rd, exc_timeout}, 32'h1);
    chk("tmo_exa", exception_address, 32'hFC);
    step();
    chk("tmo_pc", pc_output, 32'hFC);
    step();
    chk("tmo_sticky", {31'd0, exc_timeout}, 32'h1);
`else
    chk("tmo_tied", {31'd0, exc_timeout}, 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
